p_shfrot_arb: RTL

P_SHFROT_ARB -- requirements
Module: p_shfrot_arb

---
 rtl/p_shfrot_arb.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/p_shfrot_arb.sv
// Two-requester arbiter in front of one shared packed shift/rotate unit, with a 1-entry response buffer per requester.
// Define P_SHFROT_ARB_FIXED_PRIO_EN to make requester 0 win every tie; the default build arbitrates round-robin.

module p_shfrot (
  input  logic [31:0] crs1,
  input  logic [4:0]  shamt,
  input  logic [4:0]  pw,
  input  logic        shift,
  input  logic        rotate,
  input  logic        left,
  input  logic        right,
  output logic [31:0] result
);
  logic        is_rot;
  logic        is_right;
  logic [31:0] by_w [5];

  assign is_rot   = rotate & ~shift;
  assign is_right = right & ~left;

  // Lane width 32 >> gi; the amount is taken modulo the lane width.
  for (genvar gi = 0; gi < 5; gi++) begin : g_width
    localparam int W = 32 >> gi;
    logic [31:0] res_w;

    always_comb begin
      int       amt;
      int       pos;
      int       src;
      logic     hit;
      logic [4:0] idx;
      res_w = '0;
      amt   = int'(shamt) & (W - 1);
      for (int i = 0; i < 32; i++) begin
        pos = i % W;
        hit = 1'b1;
        if (is_rot) begin
          src = is_right ? (pos + amt) % W : (pos - amt + W) % W;
        end else if (is_right) begin
          src = pos + amt;
          hit = (src < W);
        end else begin
          src = pos - amt;
          hit = (src >= 0);
        end
        idx      = hit ? 5'(i - pos + src) : 5'(i);
        res_w[i] = hit & crs1[idx];
      end
    end

    assign by_w[gi] = res_w;
  end

  // Narrowest selected width wins when pw is multi-hot.
  always_comb begin
    if (pw[4])      result = by_w[4];
    else if (pw[3]) result = by_w[3];
    else if (pw[2]) result = by_w[2];
    else if (pw[1]) result = by_w[1];
    else if (pw[0]) result = by_w[0];
    else            result = '0;
  end
endmodule

module p_shfrot_arb #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        rq0_valid,
  output logic        rq0_ready,
  input  logic [31:0] rq0_crs1,
  input  logic [4:0]  rq0_shamt,
  input  logic [4:0]  rq0_pw,
  input  logic [1:0]  rq0_op,
  output logic        rs0_valid,
  input  logic        rs0_ready,
  output logic [31:0] rs0_result,
  input  logic        rq1_valid,
  output logic        rq1_ready,
  input  logic [31:0] rq1_crs1,
  input  logic [4:0]  rq1_shamt,
  input  logic [4:0]  rq1_pw,
  input  logic [1:0]  rq1_op,
  output logic        rs1_valid,
  input  logic        rs1_ready,
  output logic [31:0] rs1_result
);
  typedef enum logic [1:0] {ST_EMPTY, ST_HOLD0, ST_HOLD1} stage_e;

  stage_e      stage_q;
  logic [31:0] crs1_q, crs1_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [4:0]  pw_q, pw_d;
  logic [1:0]  op_q, op_d;
  logic        rs0_valid_q, rs1_valid_q;
  logic [31:0] rs0_result_q, rs1_result_q;
  logic        elig0, elig1, cand0, cand1, gnt0, gnt1;
  logic [31:0] unit_res;

  // A requester may issue only if its buffer will be free when the result lands.
  assign elig0 = (stage_q != ST_HOLD0) && (!rs0_valid_q || rs0_ready);
  assign elig1 = (stage_q != ST_HOLD1) && (!rs1_valid_q || rs1_ready);
  assign cand0 = rq0_valid && elig0;
  assign cand1 = rq1_valid && elig1;

`ifdef P_SHFROT_ARB_FIXED_PRIO_EN
  assign gnt0 = cand0;
  assign gnt1 = cand1 && !cand0;
`else
  logic ptr_q;

  assign gnt0 = cand0 && (!cand1 || !ptr_q);
  assign gnt1 = cand1 && (!cand0 || ptr_q);

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn)  ptr_q <= RR_INIT;
    else if (gnt0)  ptr_q <= 1'b1;
    else if (gnt1)  ptr_q <= 1'b0;
  end
`endif

  assign rq0_ready = gnt0 & g_resetn;
  assign rq1_ready = gnt1 & g_resetn;

  assign crs1_d  = gnt1 ? rq1_crs1  : rq0_crs1;
  assign shamt_d = gnt1 ? rq1_shamt : rq0_shamt;
  assign pw_d    = gnt1 ? rq1_pw    : rq0_pw;
  assign op_d    = gnt1 ? rq1_op    : rq0_op;

  p_shfrot u_shfrot (
    .crs1   (crs1_q),
    .shamt  (shamt_q),
    .pw     (pw_q),
    .shift  (!op_q[1]),
    .rotate (op_q[1]),
    .left   (!op_q[0]),
    .right  (op_q[0]),
    .result (unit_res)
  );

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      stage_q      <= ST_EMPTY;
      crs1_q       <= '0;
      shamt_q      <= '0;
      pw_q         <= '0;
      op_q         <= '0;
      rs0_valid_q  <= 1'b0;
      rs1_valid_q  <= 1'b0;
      rs0_result_q <= '0;
      rs1_result_q <= '0;
    end else begin
      if (gnt0 || gnt1) begin
        stage_q <= gnt0 ? ST_HOLD0 : ST_HOLD1;
        crs1_q  <= crs1_d;
        shamt_q <= shamt_d;
        pw_q    <= pw_d;
        op_q    <= op_d;
      end else begin
        stage_q <= ST_EMPTY;
      end

      // A fresh write overrides a same-edge consume.
      if (stage_q == ST_HOLD0) begin
        rs0_result_q <= unit_res;
        rs0_valid_q  <= 1'b1;
      end else if (rs0_valid_q && rs0_ready) begin
        rs0_valid_q  <= 1'b0;
      end

      if (stage_q == ST_HOLD1) begin
        rs1_result_q <= unit_res;
        rs1_valid_q  <= 1'b1;
      end else if (rs1_valid_q && rs1_ready) begin
        rs1_valid_q  <= 1'b0;
      end
    end
  end

  assign rs0_valid  = rs0_valid_q;
  assign rs1_valid  = rs1_valid_q;
  assign rs0_result = rs0_result_q;
  assign rs1_result = rs1_result_q;
endmodule
